// File: rtl/dac_cfg_loader.sv
// Serial configuration loader for a multi-channel DAC: framed, parity-checked
// words land in per-channel shadow registers and move to the outputs on ldac.
module dac_cfg_loader #(
    parameter int           NCH     = 4,
    parameter int           W       = 8,
    parameter bit           AUTO_LD = 1'b0,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sdi,
    input  logic             ldac,
    input  logic             clr_err,
    output logic [NCH*W-1:0] dout,
    output logic [NCH-1:0]   pend,
    output logic             busy,
    output logic             frame_ok,
    output logic             par_err,
    output logic             addr_err
);

    localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW = AW + W;
    localparam int CW = 5;

    // state | meaning
    // IDLE  | waiting for start bit
    // ADDR  | shifting address bits, cnt_q counts down to the last one
    // DATA  | shifting data bits, cnt_q counts down to the last one
    // PAR   | parity bit on sdi, frame judged and committed at this edge
    typedef enum logic [1:0] {IDLE, ADDR, DATA, PAR} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic            par_q, par_d;
    logic [W-1:0]    shadow_q [NCH];
    logic [W-1:0]    shadow_d [NCH];
    logic [W-1:0]    active_q [NCH];
    logic [W-1:0]    active_d [NCH];
    logic [NCH-1:0]  pend_q, pend_d;
    logic            frame_ok_q, frame_ok_d;
    logic            par_err_q, par_err_d;
    logic            addr_err_q, addr_err_d;

    logic [AW-1:0]   addr_w;
    logic [W-1:0]    data_w;
    logic            par_bad, addr_bad, accept;

    assign addr_w = shift_q[SW-1:W];
    assign data_w = shift_q[W-1:0];

    always_comb begin : fsm_next
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        par_bad  = 1'b0;
        addr_bad = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sdi) begin
                    state_d = ADDR;
                    cnt_d   = CW'(AW - 1);
                    shift_d = '0;
                    par_d   = 1'b0;
                end
            end
            ADDR: begin
                shift_d = {shift_q[SW-2:0], sdi};
                par_d   = par_q ^ sdi;
                if (cnt_q == '0) begin
                    state_d = DATA;
                    cnt_d   = CW'(W - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DATA: begin
                shift_d = {shift_q[SW-2:0], sdi};
                par_d   = par_q ^ sdi;
                if (cnt_q == '0) begin
                    state_d = PAR;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            PAR: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (par_q ^ sdi) begin
                    par_bad = 1'b1;
                end else if (32'(addr_w) >= NCH) begin
                    addr_bad = 1'b1;
                end else begin
                    accept = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Transfer samples the pre-edge shadow, so a frame landing on the same
    // edge as ldac stays pending for the next transfer.
    always_comb begin : dpath_next
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        if (!AUTO_LD && ldac) begin
            active_d = shadow_q;
            pend_d   = '0;
        end
        for (int k = 0; k < NCH; k++) begin
            if (accept && addr_w == AW'(k)) begin
                shadow_d[k] = data_w;
                if (AUTO_LD) begin
                    active_d[k] = data_w;
                end else begin
                    pend_d[k] = 1'b1;
                end
            end
        end
        frame_ok_d = accept;
        par_err_d  = (par_err_q & ~clr_err) | par_bad;
        addr_err_d = (addr_err_q & ~clr_err) | addr_bad;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                shadow_q[k] <= RST_VAL;
                active_q[k] <= RST_VAL;
            end
            pend_q     <= '0;
            frame_ok_q <= 1'b0;
            par_err_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            frame_ok_q <= frame_ok_d;
            par_err_q  <= par_err_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin : pack_out
        dout = '0;
        for (int k = 0; k < NCH; k++) begin
            dout[k*W +: W] = active_q[k];
        end
    end

    assign pend     = pend_q;
    assign busy     = (state_q != IDLE);
    assign frame_ok = frame_ok_q;
    assign par_err  = par_err_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_dac_cfg_loader.sv
// Bench for dac_cfg_loader: double-buffered, direct-update and 3-channel
// instances share one serial stream; frame_ok pulses are scored against a queue.
module tb_dac_cfg_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sdi, ldac, clr_err;
    logic [31:0] dout0, dout1;
    logic [23:0] dout2;
    logic [3:0]  pend0, pend1;
    logic [2:0]  pend2;
    logic        busy0, busy1, busy2;
    logic        ok0, ok1, ok2;
    logic        perr0, perr1, perr2;
    logic        aerr0, aerr1, aerr2;

    dac_cfg_loader #(.NCH(4), .W(8), .AUTO_LD(1'b0), .RST_VAL(8'h00)) dut0 (
        .clk(clk), .rst_n(rst_n), .sdi(sdi), .ldac(ldac), .clr_err(clr_err),
        .dout(dout0), .pend(pend0), .busy(busy0), .frame_ok(ok0),
        .par_err(perr0), .addr_err(aerr0));

    dac_cfg_loader #(.NCH(4), .W(8), .AUTO_LD(1'b1), .RST_VAL(8'h00)) dut1 (
        .clk(clk), .rst_n(rst_n), .sdi(sdi), .ldac(ldac), .clr_err(clr_err),
        .dout(dout1), .pend(pend1), .busy(busy1), .frame_ok(ok1),
        .par_err(perr1), .addr_err(aerr1));

    dac_cfg_loader #(.NCH(3), .W(8), .AUTO_LD(1'b0), .RST_VAL(8'h00)) dut2 (
        .clk(clk), .rst_n(rst_n), .sdi(sdi), .ldac(ldac), .clr_err(clr_err),
        .dout(dout2), .pend(pend2), .busy(busy2), .frame_ok(ok2),
        .par_err(perr2), .addr_err(aerr2));

    int n_cmp = 0;
    int n_fail = 0;
    int busy_cnt = 0;
    int ok_cnt = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [3:0]  pend;
        logic [31:0] dout0;
        logic [31:0] dout1;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    logic [7:0] shadow_m [4];
    logic [7:0] active_m [4];
    logic [7:0] auto_m [4];
    logic [3:0] pend_m;

    typedef struct {
        logic [1:0]  addr;
        logic [7:0]  data;
        bit          bad;
        bit          ldac_par;
        bit          ldac_after;
        bit          clr_after;
        logic [3:0]  exp_pend;
        logic [31:0] exp_dout;
        bit          exp_perr;
        bit          exp_aerr2;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_act();
        return {active_m[3], active_m[2], active_m[1], active_m[0]};
    endfunction

    function automatic logic [31:0] pack_auto();
        return {auto_m[3], auto_m[2], auto_m[1], auto_m[0]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            shadow_m[k] = 8'h00;
            active_m[k] = 8'h00;
            auto_m[k]   = 8'h00;
        end
        pend_m = 4'b0000;
    endtask

    task automatic model_xfer();
        for (int k = 0; k < 4; k++) active_m[k] = shadow_m[k];
        pend_m = 4'b0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sdi = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_ldac();
        ldac = 1'b1;
        model_xfer();
        tick();
        ldac = 1'b0;
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    // Bits go out MSB first: start, 2 address, 8 data, even parity (flipped if bad).
    task automatic send_frame(input logic [1:0] addr, input logic [7:0] data,
                              input bit bad, input bit ldac_par, input bit clr_par);
        logic [11:0] bits;
        logic        p;
        sb_t         e;
        p    = (^{addr, data}) ^ bad;
        bits = {1'b1, addr, data, p};
        for (int i = 11; i >= 0; i--) begin
            sdi = bits[i];
            if (i == 0) begin
                ldac    = ldac_par;
                clr_err = clr_par;
                if (ldac_par) model_xfer();
                if (!bad) begin
                    shadow_m[addr] = data;
                    pend_m[addr]   = 1'b1;
                    auto_m[addr]   = data;
                    e.pend  = pend_m;
                    e.dout0 = pack_act();
                    e.dout1 = pack_auto();
                    sb_q.push_back(e);
                end
            end
            tick();
        end
        sdi     = 1'b0;
        ldac    = 1'b0;
        clr_err = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy0) busy_cnt++;
            if (ok0) begin
                ok_cnt++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected_ok: got frame_ok=1 expected no pulse");
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("sb_pend", {28'd0, pend0}, {28'd0, mon_e.pend});
                    chk("sb_dout0", dout0, mon_e.dout0);
                    chk("sb_dout_auto", dout1, mon_e.dout1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ok_before;
        logic [11:0] pbits;

        vt[0] = '{2'd2, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 32'h00000000, 1'b0, 1'b0};
        vt[1] = '{2'd2, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 32'h00000000, 1'b1, 1'b0};
        vt[2] = '{2'd0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0101, 32'h00000000, 1'b0, 1'b0};
        vt[3] = '{2'd3, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 32'hF0A50011, 1'b0, 1'b1};
        vt[4] = '{2'd2, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 32'hF0A50011, 1'b0, 1'b1};
        vt[5] = '{2'd1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 32'hF05A0011, 1'b0, 1'b1};
        vt[6] = '{2'd3, 8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 32'hF05A3C11, 1'b1, 1'b1};
        vt[7] = '{2'd3, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 32'h815A3C11, 1'b0, 1'b0};

        rst_n = 1'b0; sdi = 1'b0; ldac = 1'b0; clr_err = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        mon_en = 1'b1;

        chk("rst_dout", dout0, 32'h0);
        chk("rst_pend", {28'd0, pend0}, 32'h0);
        chk("rst_busy", {31'd0, busy0}, 32'h0);
        chk("rst_frame_ok", {31'd0, ok0}, 32'h0);
        chk("rst_errs", {30'd0, perr0, aerr0}, 32'h0);
        chk("rst_dout_auto", dout1, 32'h0);

        for (int i = 0; i < 8; i++) begin
            busy_cnt  = 0;
            ok_before = ok_cnt;
            send_frame(vt[i].addr, vt[i].data, vt[i].bad, vt[i].ldac_par, 1'b0);
            idle(1);
            chk($sformatf("v%0d_busy_cycles", i), busy_cnt, 11);
            chk($sformatf("v%0d_ok_pulses", i), ok_cnt - ok_before, vt[i].bad ? 0 : 1);
            if (vt[i].clr_after) do_clr();
            if (vt[i].ldac_after) do_ldac();
            chk($sformatf("v%0d_pend", i), {28'd0, pend0}, {28'd0, vt[i].exp_pend});
            chk($sformatf("v%0d_dout", i), dout0, vt[i].exp_dout);
            chk($sformatf("v%0d_par_err", i), {31'd0, perr0}, {31'd0, vt[i].exp_perr});
            chk($sformatf("v%0d_addr_err_nch3", i), {31'd0, aerr2}, {31'd0, vt[i].exp_aerr2});
            chk($sformatf("v%0d_dout_auto", i), dout1, pack_auto());
            chk($sformatf("v%0d_pend_auto", i), {28'd0, pend1}, 32'h0);
        end

        // Reset during the 5th data bit of a ch1 frame.
        pbits = {1'b1, 2'd1, 8'h77, ^{2'd1, 8'h77}};
        for (int i = 11; i >= 5; i--) begin
            sdi = pbits[i];
            tick();
        end
        sdi = pbits[4];
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sdi = 1'b0;
        model_reset();
        chk("midrst_busy", {31'd0, busy0}, 32'h0);
        chk("midrst_pend", {28'd0, pend0}, 32'h0);
        chk("midrst_dout", dout0, 32'h0);
        chk("midrst_dout_auto", dout1, 32'h0);
        idle(2);
        chk("midrst_stays_idle", {31'd0, busy0}, 32'h0);
        ok_before = ok_cnt;
        send_frame(2'd1, 8'h77, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("midrst_next_ok", ok_cnt - ok_before, 1);
        do_ldac();
        chk("midrst_next_dout", dout0, 32'h00007700);
        chk("midrst_next_auto", dout1, 32'h00007700);

        // Back-to-back frames, no idle gap.
        ok_before = ok_cnt;
        send_frame(2'd0, 8'h01, 1'b0, 1'b0, 1'b0);
        send_frame(2'd3, 8'hFE, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("b2b_ok_pulses", ok_cnt - ok_before, 2);
        chk("b2b_pend", {28'd0, pend0}, 32'h9);
        chk("b2b_dout_auto", dout1, 32'hFE007701);
        do_ldac();
        chk("b2b_dout", dout0, 32'hFE007701);
        chk("b2b_pend_clr", {28'd0, pend0}, 32'h0);

        // clr_err on the same edge as a new error: the error wins.
        send_frame(2'd2, 8'hA5, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("clr_vs_par_err", {31'd0, perr0}, 32'h1);
        send_frame(2'd3, 8'h42, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("clr_vs_addr_err_nch3", {31'd0, aerr2}, 32'h1);
        chk("clr_keeps_par_err", {31'd0, perr0}, 32'h0);
        do_clr();
        chk("clr_after_addr_err", {31'd0, aerr2}, 32'h0);
        chk("nch3_no_ch3_pend", {29'd0, pend2}, 32'h0);

        idle(2);
        chk("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_cfg_loader.md
DAC_CFG_LOADER -- requirements
Module: dac_cfg_loader

Interface
REQ-001 Parameter NCH, default 4, number of DAC channels (1..16).
REQ-002 Parameter W, default 8, data word width per channel (1..16).
REQ-003 Parameter AUTO_LD, default 0: 0 = double-buffered (ldac transfers), 1 = direct update.
REQ-004 Parameter RST_VAL, default 0, W-bit reset value of every shadow and active word.
REQ-005 Derived AW = max(1, ceil(log2(NCH))), address field width.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 sdi  input  1  serial config data, one bit per clk.
REQ-009 ldac  input  1  level-sampled load strobe; copies all shadow words to active words.
REQ-010 clr_err  input  1  clears sticky error flags.
REQ-011 dout  output  NCH*W  active words; channel k occupies bits [k*W+W-1 : k*W].
REQ-012 pend  output  NCH  per-channel flag: shadow written, not yet transferred.
REQ-013 busy  output  1  high while a frame is in progress (state != IDLE).
REQ-014 frame_ok  output  1  one-cycle pulse after an accepted frame.
REQ-015 par_err  output  1  sticky parity error flag.
REQ-016 addr_err  output  1  sticky flag for an address >= NCH.

Function
REQ-017 Frame format, in order: start bit '1', AW address bits MSB first, W data bits MSB first, one even-parity bit; total length 2+AW+W cycles.
REQ-018 FSM states: IDLE, ADDR, DATA, PAR; no other states reachable.
REQ-019 IDLE: sdi=0 -> stay IDLE; sdi=1 -> ADDR (start bit consumed).
REQ-020 ADDR: shift AW bits, then -> DATA. DATA: shift W bits, then -> PAR. PAR: one cycle, then -> IDLE unconditionally.
REQ-021 Parity check at PAR: XOR of address bits, data bits and parity bit SHALL equal 0; otherwise the frame is rejected.
REQ-022 Rejected parity: set par_err, no shadow/active/pend change, no frame_ok.
REQ-023 Parity good but address >= NCH: set addr_err, no write, no frame_ok.
REQ-024 Accepted frame: at the PAR-cycle edge, shadow[addr] <= data; frame_ok = 1 during the following cycle only.
REQ-025 AUTO_LD=0: accepted frame sets pend[addr] at the same edge; active unchanged.
REQ-026 AUTO_LD=0, ldac=1: at the edge, active[k] <= shadow[k] (pre-edge value) for all k; pend cleared.
REQ-027 ldac coinciding with an accepted-frame edge: transfer uses pre-write shadow; pend[addr] ends 1, all other pend bits end 0.
REQ-028 AUTO_LD=1: accepted frame writes shadow and active at the same edge; pend stays 0; ldac ignored.
REQ-029 sdi is sampled every cycle; a '1' arriving in IDLE on the cycle after PAR starts a new frame (back-to-back frames, no gap required).
REQ-030 clr_err=1 clears par_err and addr_err at the edge; an error detected at the same edge wins (flag ends 1).
REQ-031 busy is high in ADDR, DATA and PAR; low in IDLE.

Reset
REQ-032 rst_n=0 at an edge: state IDLE, all shadow and active words = RST_VAL, pend = 0, par_err = 0, addr_err = 0, frame_ok = 0, shift register and bit counter = 0.
REQ-033 Reset asserted mid-frame aborts the frame with no write; busy = 0 in the cycle after the reset edge.
REQ-034 Reset has priority over ldac, clr_err and frame completion.

Verification (NCH=4, W=8, RST_VAL=0, AUTO_LD=0 unless noted)
REQ-035 sdi sequence 1,1,0,1,0,1,0,0,1,0,1,1 (ch2, 0xA5, parity 1) -> frame_ok pulses once, pend=0100, dout=0, busy high for exactly 11 cycles.
REQ-036 Same frame with parity bit 0 -> par_err=1, pend=0000, no frame_ok; subsequent clr_err -> par_err=0.
REQ-037 After REQ-035, ldac=1 for one cycle -> dout[23:16]=0xA5, other channels 0x00, pend=0000.
REQ-038 rst_n=0 during the 5th data bit of a ch1 frame -> busy=0, pend=0000, dout=0; a following valid frame is accepted normally.
REQ-039 ch2 pending 0xA5; ch1 frame 0x3C accepted with ldac=1 at its PAR edge -> dout[23:16]=0xA5, dout[15:8]=0x00, pend=0010.
REQ-040 AUTO_LD=1, REQ-035 frame -> dout[23:16]=0xA5 in the same cycle frame_ok is high, pend=0000.
